hazard_scoreboard: RTL

- Parametrised successor to the pipeline hazard/branch/jump logic.
- Replaces fixed EX/MEM register compares with a per-register readiness scoreboard driven by configurable producer latencies (ALU_LAT, LOAD_LAT).
- Adds a memory-wait FSM that freezes the pipeline on dcache miss, and stall/flush performance counters.
- Sits beside the decode stage; gates ID->EX issue and drives PC/latch enables, bubbles and flushes.

---
 rtl/cpu_types_pkg.sv | 25 ++
 rtl/hazard_scoreboard_pkg.sv | 18 +
 rtl/reg_ready_counter.sv | 29 ++
 rtl/hazard_scoreboard.sv | 108 ++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU encodings: primary opcode and R-type function fields.
package cpu_types_pkg;

    typedef enum logic [5:0] {
        RTYPE = 6'h00,
        J     = 6'h02,
        JAL   = 6'h03,
        BEQ   = 6'h04,
        BNE   = 6'h05,
        ADDI  = 6'h08,
        ORI   = 6'h0D,
        LW    = 6'h23,
        SW    = 6'h2B
    } opcode_t;

    typedef enum logic [5:0] {
        JR   = 6'h08,
        ADD  = 6'h20,
        ADDU = 6'h21,
        SUB  = 6'h22,
        SUBU = 6'h23,
        SLT  = 6'h2A
    } funct_t;

endpackage

// File: rtl/hazard_scoreboard_pkg.sv
// Scoreboard-specific types: memory-wait FSM state and operand-usage predicates.
package hazard_scoreboard_pkg;
    import cpu_types_pkg::*;

    typedef enum logic [0:0] {
        RUN     = 1'b0,
        MEMWAIT = 1'b1
    } hz_state_t;

    function automatic logic uses_rt(input opcode_t op);
        return op inside {RTYPE, BEQ, BNE, SW};
    endfunction

    function automatic logic uses_rs(input opcode_t op);
        return !(op inside {J, JAL});
    endfunction

endpackage

// File: rtl/reg_ready_counter.sv
// Cycles-until-readable counter for one architectural register.
module reg_ready_counter #(
    parameter int CW = 1
) (
    input  logic          CLK,
    input  logic          nRST,
    input  logic          hold,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    output logic          busy
);

    logic [CW-1:0] cnt;

    // A fresh producer overrides both the decrement and any older value.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            cnt <= '0;
        end else if (!hold) begin
            if (load)
                cnt <= load_val;
            else if (cnt != '0)
                cnt <= cnt - CW'(1);
        end
    end

    assign busy = (cnt != '0);

endmodule

// File: rtl/hazard_scoreboard.sv
// Decode-side issue gate: register readiness scoreboard, dcache-miss freeze,
// branch/jump flush and stall/flush performance counters.
module hazard_scoreboard
    import cpu_types_pkg::*;
    import hazard_scoreboard_pkg::*;
#(
    parameter int NREGS    = 32,
    parameter int REG_W    = 5,
    parameter int ALU_LAT  = 0,
    parameter int LOAD_LAT = 1,
    parameter int CNT_W    = 32
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             id_valid,
    input  opcode_t          id_opcode,
    input  funct_t           id_func,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_wen,
    input  logic [REG_W-1:0] id_wsel,
    input  logic             id_equal,
    input  logic             mem_req,
    input  logic             dhit,
    output logic             issue,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             idex_bubble,
    output logic             ifid_flush,
    output logic             freeze,
    output logic             mem_wait,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    localparam int MAX_LAT = (ALU_LAT > LOAD_LAT) ? ALU_LAT : LOAD_LAT;
    localparam int CW      = (MAX_LAT < 1) ? 1 : $clog2(MAX_LAT + 1);

    logic [NREGS-1:0] busy;
    logic             hazard;
    logic             taken;
    logic             load_en;
    logic [CW-1:0]    load_val;
    hz_state_t        state, state_nxt;

    assign busy[0] = 1'b0;

    assign freeze = mem_req & ~dhit;
    assign hazard = id_valid & ((uses_rs(id_opcode) & busy[id_rs]) |
                                (uses_rt(id_opcode) & busy[id_rt]));

    assign issue       = id_valid & ~hazard & ~freeze;
    assign pc_en       = ~freeze & ~hazard;
    assign ifid_en     = ~freeze & ~hazard;
    assign idex_bubble = ~freeze & hazard;

    assign taken = ((id_opcode == BEQ) &  id_equal) |
                   ((id_opcode == BNE) & ~id_equal) |
                    (id_opcode == J) | (id_opcode == JAL) |
                   ((id_opcode == RTYPE) & (id_func == JR));
    assign ifid_flush = issue & taken;

    assign load_en  = issue & id_wen & (id_wsel != '0);
    assign load_val = (id_opcode == LW) ? CW'(LOAD_LAT) : CW'(ALU_LAT);

    for (genvar r = 1; r < NREGS; r++) begin : g_reg
        reg_ready_counter #(.CW(CW)) u_cnt (
            .CLK      (CLK),
            .nRST     (nRST),
            .hold     (freeze),
            .load     (load_en && (id_wsel == REG_W'(r))),
            .load_val (load_val),
            .busy     (busy[r])
        );
    end

    // Memory-wait FSM: observational only, freeze itself stays combinational.
    always_comb begin
        state_nxt = state;
        case (state)
            RUN:     if (freeze) state_nxt = MEMWAIT;
            MEMWAIT: if (dhit | ~mem_req) state_nxt = RUN;
            default: state_nxt = RUN;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST)
            state <= RUN;
        else
            state <= state_nxt;
    end

    assign mem_wait = (state == MEMWAIT);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            stall_count <= '0;
            flush_count <= '0;
        end else begin
            if (hazard & ~freeze)
                stall_count <= stall_count + CNT_W'(1);
            if (ifid_flush)
                flush_count <= flush_count + CNT_W'(1);
        end
    end

endmodule
